// File: rtl/pc_sequencer.sv
// Configurable-width program counter with segmented staging load, prescaled free-run,
// absolute/relative branches and a bounded call/return stack.
module pc_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned LOAD_W      = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned PRESCALE    = 4,
  localparam int unsigned NSEG       = WIDTH / LOAD_W,
  localparam int unsigned SEL_W      = (NSEG > 1) ? $clog2(NSEG) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [LOAD_W-1:0]  i_load_data,
  input  logic [SEL_W-1:0]   i_load_sel,
  input  logic               i_load_stb,
  input  logic               i_commit,
  input  logic               i_step,
  input  logic               i_run_start,
  input  logic               i_run_stop,
  input  logic               i_branch,
  input  logic               i_branch_rel,
  input  logic [WIDTH-1:0]   i_target,
  input  logic               i_call,
  input  logic               i_ret,
  output logic [WIDTH-1:0]   o_pc,
  output logic [WIDTH-1:0]   o_staging,
  output logic               o_running,
  output logic               o_stack_full,
  output logic               o_stack_empty,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state;
  logic [PS_W-1:0]  r_presc;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_staging;
  logic [SP_W-1:0]  r_sp;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] r_stack [STACK_DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_tick;
  logic             w_do_push;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_top;

  assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_tick    = (r_state == RUN) && (r_presc == PS_W'(PRESCALE - 1));
  assign w_pc_inc  = r_pc + WIDTH'(1);
  assign w_top     = r_stack[IDX_W'(r_sp - SP_W'(1))];
  assign w_do_push = !i_commit && !i_ret && i_call && !w_full;

  // Run-mode FSM and prescaler; run_stop dominates run_start.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_presc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_presc <= '0;
          if (i_run_start && !i_run_stop) r_state <= RUN;
        end
        RUN: begin
          if (i_run_stop) begin
            r_state <= IDLE;
            r_presc <= '0;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_presc <= '0;
        end
      endcase
    end
  end

  // Staging segment writes; out-of-range selects match no segment.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_staging <= '0;
    end else if (i_load_stb) begin
      for (int unsigned s = 0; s < NSEG; s++) begin
        if (i_load_sel == SEL_W'(s)) r_staging[s*LOAD_W +: LOAD_W] <= i_load_data;
      end
    end
  end

  // Single PC action per cycle, highest priority first.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc        <= '0;
      r_sp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_commit) begin
      r_pc <= r_staging;
    end else if (i_ret) begin
      if (!w_empty) begin
        r_pc <= w_top;
        r_sp <= r_sp - SP_W'(1);
      end else begin
        r_underflow <= 1'b1;
      end
    end else if (i_call) begin
      if (!w_full) begin
        r_pc <= i_target;
        r_sp <= r_sp + SP_W'(1);
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (i_branch) begin
      r_pc <= i_branch_rel ? r_pc + i_target : i_target;
    end else if (i_step || w_tick) begin
      r_pc <= w_pc_inc;
    end
  end

  // Return-address storage; contents are not reset.
  always_ff @(posedge i_clock) begin
    if (w_do_push) r_stack[IDX_W'(r_sp)] <= w_pc_inc;
  end

  assign o_pc          = r_pc;
  assign o_staging     = r_staging;
  assign o_running     = (r_state == RUN);
  assign o_stack_full  = w_full;
  assign o_stack_empty = w_empty;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed plan scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned LOAD_W   = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned NSEG     = WIDTH / LOAD_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [LOAD_W-1:0] load_data = '0;
  logic [0:0]        load_sel = '0;
  logic              load_stb = 1'b0, commit = 1'b0, step = 1'b0;
  logic              run_start = 1'b0, run_stop = 1'b0;
  logic              branch = 1'b0, branch_rel = 1'b0, call = 1'b0, ret = 1'b0;
  logic [WIDTH-1:0]  target = '0;
  logic [WIDTH-1:0]  pc, staging;
  logic              running, stack_full, stack_empty, overflow, underflow;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_pc, m_stage;
  logic [WIDTH-1:0] m_stack[$];
  bit               m_running, m_ovf, m_unf;
  int               m_rc;

  pc_sequencer #(.WIDTH(WIDTH), .LOAD_W(LOAD_W), .STACK_DEPTH(DEPTH), .PRESCALE(PRESCALE)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_load_data(load_data), .i_load_sel(load_sel),
    .i_load_stb(load_stb), .i_commit(commit), .i_step(step), .i_run_start(run_start),
    .i_run_stop(run_stop), .i_branch(branch), .i_branch_rel(branch_rel), .i_target(target),
    .i_call(call), .i_ret(ret), .o_pc(pc), .o_staging(staging), .o_running(running),
    .o_stack_full(stack_full), .o_stack_empty(stack_empty), .o_overflow(overflow),
    .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_pc = '0; m_stage = '0; m_stack.delete();
    m_running = 0; m_ovf = 0; m_unf = 0; m_rc = 0;
  endtask

  task automatic model_edge();
    logic [WIDTH-1:0] nxt;
    bit tick;
    nxt  = m_pc;
    tick = m_running && ((m_rc % PRESCALE) == PRESCALE - 1);
    if (commit) nxt = m_stage;
    else if (ret) begin
      if (m_stack.size() > 0) nxt = m_stack.pop_back();
      else m_unf = 1;
    end else if (call) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back(m_pc + 16'd1);
        nxt = target;
      end else m_ovf = 1;
    end else if (branch) nxt = branch_rel ? m_pc + target : target;
    else if (step || tick) nxt = m_pc + 16'd1;
    if (load_stb && int'(load_sel) < NSEG) m_stage[int'(load_sel)*LOAD_W +: LOAD_W] = load_data;
    if (m_running) begin
      if (run_stop) begin m_running = 0; m_rc = 0; end
      else m_rc++;
    end else if (run_start && !run_stop) begin
      m_running = 1; m_rc = 0;
    end
    m_pc = nxt;
  endtask

  task automatic clear_in();
    load_stb = 0; commit = 0; step = 0; run_start = 0; run_stop = 0;
    branch = 0; branch_rel = 0; call = 0; ret = 0;
  endtask

  // One clock: advance model on current inputs, then sample 1ns after the edge.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic load_seg(input logic [0:0] sel, input logic [LOAD_W-1:0] d);
    load_stb = 1; load_sel = sel; load_data = d;
    cyc();
  endtask

  task automatic set_pc(input logic [WIDTH-1:0] v);
    load_seg(1'b0, v[7:0]);
    load_seg(1'b1, v[15:8]);
    commit = 1;
    cyc();
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", pc); else n_pass++;
    n_total++; if (staging !== 16'h0000) $display("FAIL reset_staging: got %h want 0000", staging); else n_pass++;
    n_total++; if ({running, stack_full, stack_empty, overflow, underflow} !== 5'b00100)
      $display("FAIL reset_flags: got %b want 00100", {running, stack_full, stack_empty, overflow, underflow});
    else n_pass++;
  endtask

  task automatic test_load_commit();
    load_seg(1'b0, 8'h34);
    load_seg(1'b1, 8'h12);
    n_total++; if (staging !== 16'h1234) $display("FAIL load_staging: got %h want 1234", staging); else n_pass++;
    n_total++; if (pc !== 16'h0000) $display("FAIL load_pc_precommit: got %h want 0000", pc); else n_pass++;
    commit = 1; cyc();
    n_total++; if (pc !== 16'h1234) $display("FAIL commit_pc: got %h want 1234", pc); else n_pass++;
  endtask

  task automatic test_run_wrap();
    set_pc(16'hFFFE);
    run_start = 1; cyc();
    n_total++; if (running !== 1'b1) $display("FAIL run_enter: got %b want 1", running); else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 3) begin
        n_total++; if (pc !== 16'hFFFE) $display("FAIL run_pretick: got %h want fffe", pc); else n_pass++;
      end
      if (i == 4) begin
        n_total++; if (pc !== 16'hFFFF) $display("FAIL run_tick1: got %h want ffff", pc); else n_pass++;
      end
      if (i == 8) begin
        n_total++; if (pc !== 16'h0000) $display("FAIL run_wrap: got %h want 0000", pc); else n_pass++;
      end
    end
    run_stop = 1; cyc();
    n_total++; if (running !== 1'b0) $display("FAIL run_stop: got %b want 0", running); else n_pass++;
    repeat (6) cyc();
    n_total++; if (pc !== 16'h0000) $display("FAIL run_frozen: got %h want 0000", pc); else n_pass++;
  endtask

  task automatic test_branch();
    set_pc(16'h0100);
    branch = 1; branch_rel = 1; target = 16'hFFF0; cyc();
    n_total++; if (pc !== 16'h00F0) $display("FAIL branch_rel: got %h want 00f0", pc); else n_pass++;
    branch = 1; branch_rel = 0; target = 16'h0200; cyc();
    n_total++; if (pc !== 16'h0200) $display("FAIL branch_abs: got %h want 0200", pc); else n_pass++;
  endtask

  task automatic test_stack();
    logic [WIDTH-1:0] exp_ret [4] = '{16'h0101, 16'h0101, 16'h0101, 16'h0011};
    set_pc(16'h0010);
    for (int i = 0; i < 4; i++) begin
      call = 1; target = 16'h0100; cyc();
    end
    n_total++; if (stack_full !== 1'b1) $display("FAIL stack_full: got %b want 1", stack_full); else n_pass++;
    call = 1; target = 16'h0700; cyc();
    n_total++; if (pc !== 16'h0100 || overflow !== 1'b1)
      $display("FAIL stack_overflow: got pc=%h ovf=%b want pc=0100 ovf=1", pc, overflow);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      ret = 1; cyc();
      n_total++; if (pc !== exp_ret[i]) $display("FAIL stack_ret%0d: got %h want %h", i, pc, exp_ret[i]); else n_pass++;
    end
    n_total++; if (stack_empty !== 1'b1) $display("FAIL stack_empty: got %b want 1", stack_empty); else n_pass++;
    ret = 1; cyc();
    n_total++; if (underflow !== 1'b1 || pc !== 16'h0011)
      $display("FAIL stack_underflow: got unf=%b pc=%h want unf=1 pc=0011", underflow, pc);
    else n_pass++;
  endtask

  task automatic test_priority();
    call = 1; target = 16'h0500; cyc();
    commit = 1; ret = 1; step = 1; cyc();
    n_total++; if (pc !== 16'h0010 || stack_empty !== 1'b0)
      $display("FAIL prio_commit: got pc=%h empty=%b want pc=0010 empty=0", pc, stack_empty);
    else n_pass++;
    ret = 1; cyc();
    n_total++; if (pc !== 16'h0012) $display("FAIL prio_stack_kept: got %h want 0012", pc); else n_pass++;
    run_start = 1; cyc();
    repeat (3) cyc();
    branch = 1; branch_rel = 0; target = 16'h0800; cyc();
    n_total++; if (pc !== 16'h0800) $display("FAIL prio_tick_branch: got %h want 0800", pc); else n_pass++;
    repeat (3) cyc();
    n_total++; if (pc !== 16'h0800) $display("FAIL prio_no_early_tick: got %h want 0800", pc); else n_pass++;
    cyc();
    n_total++; if (pc !== 16'h0801) $display("FAIL prio_next_tick: got %h want 0801", pc); else n_pass++;
    run_stop = 1; cyc();
  endtask

  task automatic test_call_wrap();
    do_reset();
    set_pc(16'hFFFF);
    call = 1; target = 16'h0005; cyc();
    n_total++; if (pc !== 16'h0005) $display("FAIL callwrap_jump: got %h want 0005", pc); else n_pass++;
    ret = 1; cyc();
    n_total++; if (pc !== 16'h0000) $display("FAIL callwrap_ret: got %h want 0000", pc); else n_pass++;
  endtask

  task automatic test_async_reset();
    set_pc(16'h4321);
    call = 1; target = 16'h0300; cyc();
    ret = 1; cyc();
    ret = 1; cyc();
    run_start = 1; cyc();
    repeat (2) cyc();
    #2 rst_n = 0;
    #1;
    n_total++; if (pc !== 16'h0000 || staging !== 16'h0000)
      $display("FAIL async_pc: got pc=%h staging=%h want 0000/0000", pc, staging);
    else n_pass++;
    n_total++; if ({running, stack_empty, underflow, overflow} !== 4'b0100)
      $display("FAIL async_flags: got %b want 0100", {running, stack_empty, underflow, overflow});
    else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        load_stb   = ($urandom_range(0, 2) == 0);
        load_sel   = 1'($urandom_range(0, 1));
        load_data  = 8'($urandom);
        commit     = ($urandom_range(0, 15) == 0);
        ret        = ($urandom_range(0, 6) == 0);
        call       = ($urandom_range(0, 6) == 0);
        branch     = ($urandom_range(0, 7) == 0);
        branch_rel = 1'($urandom_range(0, 1));
        step       = ($urandom_range(0, 7) == 0);
        run_start  = ($urandom_range(0, 9) == 0);
        run_stop   = ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 3))
          0: target = 16'hFFFF;
          1: target = 16'h0000;
          default: target = 16'($urandom);
        endcase
        cyc();
        n_total++; if (pc !== m_pc) $display("FAIL rnd_pc c%0d: got %h want %h", i, pc, m_pc); else n_pass++;
        n_total++; if (staging !== m_stage) $display("FAIL rnd_staging c%0d: got %h want %h", i, staging, m_stage); else n_pass++;
        n_total++; if (running !== m_running) $display("FAIL rnd_running c%0d: got %b want %b", i, running, m_running); else n_pass++;
        n_total++; if (stack_full !== (m_stack.size() == DEPTH) || stack_empty !== (m_stack.size() == 0))
          $display("FAIL rnd_stackflags c%0d: got full=%b empty=%b want depth %0d", i, stack_full, stack_empty, m_stack.size());
        else n_pass++;
        n_total++; if (overflow !== m_ovf || underflow !== m_unf)
          $display("FAIL rnd_sticky c%0d: got ovf=%b unf=%b want %b %b", i, overflow, underflow, m_ovf, m_unf);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_run_wrap();
    test_branch();
    test_stack();
    test_priority();
    test_call_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
